// File: rtl/ntt_coef_sink_if.sv
// Bundled stream, control, read and status signals between the NTT output
// and the coefficient sink. Port names match the sink's pin list.
interface ntt_coef_sink_if #(
  parameter int AW = 8
);
  logic          sink_valid_i;
  logic [31:0]   sink_data_i;
  logic          sink_clear_i;
  logic          sink_release_i;
  logic          sink_rd_req_i;
  logic [AW-1:0] sink_rd_addr_i;
  logic          sink_rd_valid_o;
  logic [31:0]   sink_rd_data_o;
  logic          sink_rd_err_o;
  logic [AW:0]   sink_count_o;
  logic          sink_full_o;
  logic          sink_done_o;
  logic          sink_ovf_o;
  logic          sink_range_err_o;

  modport master (
    output sink_valid_i, sink_data_i, sink_clear_i, sink_release_i,
           sink_rd_req_i, sink_rd_addr_i,
    input  sink_rd_valid_o, sink_rd_data_o, sink_rd_err_o, sink_count_o,
           sink_full_o, sink_done_o, sink_ovf_o, sink_range_err_o
  );

  modport slave (
    input  sink_valid_i, sink_data_i, sink_clear_i, sink_release_i,
           sink_rd_req_i, sink_rd_addr_i,
    output sink_rd_valid_o, sink_rd_data_o, sink_rd_err_o, sink_count_o,
           sink_full_o, sink_done_o, sink_ovf_o, sink_range_err_o
  );
endinterface

// File: rtl/ntt_coef_sink.sv
// Captures one N-coefficient NTT frame, reduces each value to [0,Q), stores
// it by arrival index and serves 1-cycle-latency random reads once full.
module ntt_coef_sink #(
  parameter int N = 256,
  parameter int Q = 8380417
) (
  input logic             sink_clk_i,
  input logic             sink_rst_ni,
  ntt_coef_sink_if.slave  bus
);
  localparam int AW = $clog2(N);
  localparam int DW = $clog2(Q);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  localparam logic signed [32:0] Q_S      = 33'(Q);
  localparam logic signed [32:0] ZERO_S   = 33'sd0;
  localparam logic [AW:0]        LAST_IDX = (AW+1)'(N-1);
  localparam logic [AW:0]        ONE_CNT  = (AW+1)'(1);

  logic [0:0]        state_r;
  logic [AW:0]       count_r;
  logic              done_r;
  logic              ovf_r;
  logic              range_err_r;
  logic              rd_valid_r;
  logic              rd_err_r;
  logic [31:0]       rd_data_r;
  logic [DW-1:0]     mem_r [N];

  logic signed [32:0] x_s;
  logic signed [32:0] sum_s;
  logic [DW-1:0]      red_s;
  logic               red_err_s;
  logic               cap_s;
  logic [AW-1:0]      waddr_s;

  // Reduce the signed input to canonical form; out-of-range values become 0
  always_comb begin
    x_s       = {bus.sink_data_i[31], bus.sink_data_i};
    sum_s     = ZERO_S;
    red_err_s = 1'b0;
    if ((x_s < -Q_S) || (x_s >= (Q_S <<< 1))) begin
      red_err_s = 1'b1;
    end else if (x_s < ZERO_S) begin
      sum_s = x_s + Q_S;
    end else if (x_s < Q_S) begin
      sum_s = x_s;
    end else begin
      sum_s = x_s - Q_S;
    end
    red_s = sum_s[DW-1:0];
  end

  // Write enable/address; a release in FULL restarts the frame at index 0
  always_comb begin
    cap_s   = 1'b0;
    waddr_s = count_r[AW-1:0];
    if (bus.sink_clear_i || !bus.sink_valid_i) begin
      cap_s = 1'b0;
    end else if (state_r == ST_FILL) begin
      cap_s = 1'b1;
    end else if (bus.sink_release_i) begin
      cap_s   = 1'b1;
      waddr_s = '0;
    end else begin
      cap_s = 1'b0;
    end
  end

  // Coefficient storage, deliberately left out of reset
  always_ff @(posedge sink_clk_i) begin
    if (cap_s) begin
      mem_r[waddr_s] <= red_s;
    end
  end

  // Frame state, count, sticky flags and read port
  always_ff @(posedge sink_clk_i or negedge sink_rst_ni) begin
    if (!sink_rst_ni) begin
      state_r     <= ST_FILL;
      count_r     <= '0;
      done_r      <= 1'b0;
      ovf_r       <= 1'b0;
      range_err_r <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd_err_r    <= 1'b0;
      rd_data_r   <= 32'd0;
    end else begin
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_err_r   <= 1'b0;
      if (bus.sink_clear_i) begin
        state_r     <= ST_FILL;
        count_r     <= '0;
        ovf_r       <= 1'b0;
        range_err_r <= 1'b0;
      end else if (state_r == ST_FULL) begin
        if (bus.sink_release_i) begin
          state_r <= ST_FILL;
          count_r <= bus.sink_valid_i ? ONE_CNT : '0;
          if (bus.sink_valid_i && red_err_s) begin
            range_err_r <= 1'b1;
          end
        end else if (bus.sink_valid_i) begin
          ovf_r <= 1'b1;
        end
      end else if (bus.sink_valid_i) begin
        count_r <= count_r + ONE_CNT;
        if (red_err_s) begin
          range_err_r <= 1'b1;
        end
        if (count_r == LAST_IDX) begin
          state_r <= ST_FULL;
          done_r  <= 1'b1;
        end
      end

      // Read sees the state before this edge, so a same-cycle release still serves the old frame
      if (bus.sink_rd_req_i) begin
        if (state_r == ST_FULL) begin
          rd_valid_r <= 1'b1;
          rd_data_r  <= {{(32-DW){1'b0}}, mem_r[bus.sink_rd_addr_i]};
        end else begin
          rd_err_r  <= 1'b1;
          rd_data_r <= 32'd0;
        end
      end
    end
  end

  assign bus.sink_count_o     = count_r;
  assign bus.sink_full_o      = (state_r == ST_FULL);
  assign bus.sink_done_o      = done_r;
  assign bus.sink_ovf_o       = ovf_r;
  assign bus.sink_range_err_o = range_err_r;
  assign bus.sink_rd_valid_o  = rd_valid_r;
  assign bus.sink_rd_err_o    = rd_err_r;
  assign bus.sink_rd_data_o   = rd_data_r;
endmodule

// File: tb/tb_ntt_coef_sink.sv
// Directed bench for ntt_coef_sink: streaming, reduction, overflow,
// release/capture overlap, reset/clear aborts and gapped strobes.
module tb_ntt_coef_sink;
  localparam int N = 256;
  localparam int Q = 8380417;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;

  logic [31:0] rd_d;
  logic        rd_v;
  logic        rd_e;

  ntt_coef_sink_if #(.AW(8)) bus ();

  ntt_coef_sink #(.N(N), .Q(Q)) dut (
    .sink_clk_i  (clk),
    .sink_rst_ni (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.sink_done_o) done_seen++;
  endtask

  task automatic send(input logic [31:0] d);
    bus.sink_valid_i = 1'b1;
    bus.sink_data_i  = d;
    tick();
    bus.sink_valid_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic v, output logic e);
    bus.sink_rd_req_i  = 1'b1;
    bus.sink_rd_addr_i = a;
    tick();
    d = bus.sink_rd_data_o;
    v = bus.sink_rd_valid_o;
    e = bus.sink_rd_err_o;
    bus.sink_rd_req_i = 1'b0;
  endtask

  task automatic pulse_release();
    bus.sink_release_i = 1'b1;
    tick();
    bus.sink_release_i = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.sink_clear_i = 1'b1;
    tick();
    bus.sink_clear_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.sink_valid_i = 1'b0; bus.sink_data_i = 32'd0; bus.sink_clear_i = 1'b0;
    bus.sink_release_i = 1'b0; bus.sink_rd_req_i = 1'b0; bus.sink_rd_addr_i = 8'd0;
    rst_n = 1'b0;
    tick(); tick();
    tests++;
    if ({bus.sink_count_o, bus.sink_full_o, bus.sink_done_o, bus.sink_ovf_o, bus.sink_range_err_o,
         bus.sink_rd_valid_o, bus.sink_rd_err_o, bus.sink_rd_data_o} !== 47'd0) begin
      fails++; $display("FAIL reset_outputs: count=%0d full=%b rd_data=%0d, required all 0",
                        bus.sink_count_o, bus.sink_full_o, bus.sink_rd_data_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    done_seen = 0;
    for (int i = 0; i < N; i++) send(32'(i));
    tests++;
    if (bus.sink_done_o !== 1'b1 || bus.sink_full_o !== 1'b1 || bus.sink_count_o !== 9'd256) begin
      fails++; $display("FAIL stream_complete: done=%b full=%b count=%0d, required 1 1 256",
                        bus.sink_done_o, bus.sink_full_o, bus.sink_count_o);
    end
    tick();
    tests++;
    if (bus.sink_done_o !== 1'b0 || done_seen != 1) begin
      fails++; $display("FAIL stream_done_once: done=%b pulses=%0d, required 0 and 1", bus.sink_done_o, done_seen);
    end
    for (int a = 0; a < N; a++) begin
      rd(8'(a), rd_d, rd_v, rd_e);
      tests++;
      if (rd_v !== 1'b1 || rd_d !== 32'(a)) begin
        fails++; $display("FAIL stream_read[%0d]: valid=%b data=%0d, required 1 %0d", a, rd_v, rd_d, a);
      end
    end
    tick();
    tests++;
    if (bus.sink_rd_valid_o !== 1'b0 || bus.sink_rd_data_o !== 32'd255) begin
      fails++; $display("FAIL read_hold: valid=%b data=%0d, required 0 255", bus.sink_rd_valid_o, bus.sink_rd_data_o);
    end
    pulse_release();
    tests++;
    if (bus.sink_full_o !== 1'b0 || bus.sink_count_o !== 9'd0) begin
      fails++; $display("FAIL release_idle: full=%b count=%0d, required 0 0", bus.sink_full_o, bus.sink_count_o);
    end
  endtask

  task automatic test_reduce();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'd8380412; exp_v[1] = 32'd3; exp_v[2] = 32'd8380416; exp_v[3] = 32'd0;
    send(-32'sd5); send(32'd8380420); send(32'd8380416);
    tests++;
    if (bus.sink_range_err_o !== 1'b0) begin
      fails++; $display("FAIL range_early: range_err=%b, required 0", bus.sink_range_err_o);
    end
    send(32'd16760834);
    tests++;
    if (bus.sink_range_err_o !== 1'b1) begin
      fails++; $display("FAIL range_set: range_err=%b, required 1", bus.sink_range_err_o);
    end
    for (int i = 4; i < N; i++) send(32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(8'(a), rd_d, rd_v, rd_e);
      tests++;
      if (rd_v !== 1'b1 || rd_d !== exp_v[a]) begin
        fails++; $display("FAIL reduce[%0d]: valid=%b data=%0d, required 1 %0d", a, rd_v, rd_d, exp_v[a]);
      end
    end
    pulse_clear();
    tests++;
    if (bus.sink_range_err_o !== 1'b0 || bus.sink_full_o !== 1'b0) begin
      fails++; $display("FAIL clear_range: range_err=%b full=%b, required 0 0", bus.sink_range_err_o, bus.sink_full_o);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < N; i++) send(32'(1000 + i));
    send(32'd99);
    tests++;
    if (bus.sink_ovf_o !== 1'b1 || bus.sink_count_o !== 9'd256 || bus.sink_full_o !== 1'b1) begin
      fails++; $display("FAIL overflow: ovf=%b count=%0d full=%b, required 1 256 1",
                        bus.sink_ovf_o, bus.sink_count_o, bus.sink_full_o);
    end
    rd(8'd0, rd_d, rd_v, rd_e);
    tests++;
    if (rd_v !== 1'b1 || rd_d !== 32'd1000) begin
      fails++; $display("FAIL overflow_mem: valid=%b data=%0d, required 1 1000", rd_v, rd_d);
    end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    for (int i = 0; i < N; i++) send(32'(2000 + i));
    bus.sink_release_i = 1'b1; bus.sink_valid_i = 1'b1; bus.sink_data_i = 32'd7;
    bus.sink_rd_req_i = 1'b1; bus.sink_rd_addr_i = 8'd0;
    tick();
    bus.sink_release_i = 1'b0; bus.sink_valid_i = 1'b0; bus.sink_rd_req_i = 1'b0;
    tests++;
    if (bus.sink_rd_valid_o !== 1'b1 || bus.sink_rd_data_o !== 32'd2000) begin
      fails++; $display("FAIL read_old_frame: valid=%b data=%0d, required 1 2000",
                        bus.sink_rd_valid_o, bus.sink_rd_data_o);
    end
    tests++;
    if (bus.sink_count_o !== 9'd1 || bus.sink_full_o !== 1'b0 || bus.sink_ovf_o !== 1'b0) begin
      fails++; $display("FAIL release_capture: count=%0d full=%b ovf=%b, required 1 0 0",
                        bus.sink_count_o, bus.sink_full_o, bus.sink_ovf_o);
    end
    for (int i = 1; i < N; i++) send(32'(3000 + i));
    rd(8'd0, rd_d, rd_v, rd_e);
    tests++;
    if (rd_v !== 1'b1 || rd_d !== 32'd7) begin
      fails++; $display("FAIL release_idx0: valid=%b data=%0d, required 1 7", rd_v, rd_d);
    end
    rd(8'd1, rd_d, rd_v, rd_e);
    tests++;
    if (rd_v !== 1'b1 || rd_d !== 32'd3001) begin
      fails++; $display("FAIL release_idx1: valid=%b data=%0d, required 1 3001", rd_v, rd_d);
    end
  endtask

  task automatic test_abort();
    pulse_release();
    for (int i = 0; i < 100; i++) send(32'd5);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.sink_count_o !== 9'd0 || bus.sink_full_o !== 1'b0 || bus.sink_rd_data_o !== 32'd0) begin
      fails++; $display("FAIL async_reset: count=%0d full=%b rd_data=%0d, required 0 0 0",
                        bus.sink_count_o, bus.sink_full_o, bus.sink_rd_data_o);
    end
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < N; i++) send(32'(4000 + i));
    tick();
    tests++;
    if (done_seen != 1 || bus.sink_full_o !== 1'b1 || bus.sink_count_o !== 9'd256) begin
      fails++; $display("FAIL reset_refill: pulses=%0d full=%b count=%0d, required 1 1 256",
                        done_seen, bus.sink_full_o, bus.sink_count_o);
    end
    rd(8'd0, rd_d, rd_v, rd_e);
    tests++;
    if (rd_d !== 32'd4000) begin
      fails++; $display("FAIL reset_idx0: data=%0d, required 4000", rd_d);
    end
    // Build up both sticky flags, then abort mid-frame with clear
    pulse_release();
    send(-32'sd8380418);
    for (int i = 1; i < N; i++) send(32'd1);
    send(32'd2);
    pulse_release();
    for (int i = 0; i < 100; i++) send(32'd1);
    tests++;
    if (bus.sink_ovf_o !== 1'b1 || bus.sink_range_err_o !== 1'b1 || bus.sink_count_o !== 9'd100) begin
      fails++; $display("FAIL sticky_pre: ovf=%b range=%b count=%0d, required 1 1 100",
                        bus.sink_ovf_o, bus.sink_range_err_o, bus.sink_count_o);
    end
    bus.sink_clear_i = 1'b1; bus.sink_valid_i = 1'b1; bus.sink_data_i = 32'd5;
    tick();
    bus.sink_clear_i = 1'b0; bus.sink_valid_i = 1'b0;
    tests++;
    if (bus.sink_ovf_o !== 1'b0 || bus.sink_range_err_o !== 1'b0 || bus.sink_count_o !== 9'd0) begin
      fails++; $display("FAIL clear_abort: ovf=%b range=%b count=%0d, required 0 0 0",
                        bus.sink_ovf_o, bus.sink_range_err_o, bus.sink_count_o);
    end
    done_seen = 0;
    for (int i = 0; i < N; i++) send(32'(6000 + i));
    tick();
    rd(8'd0, rd_d, rd_v, rd_e);
    tests++;
    if (done_seen != 1 || rd_d !== 32'd6000) begin
      fails++; $display("FAIL clear_refill: pulses=%0d data=%0d, required 1 6000", done_seen, rd_d);
    end
  endtask

  task automatic test_read_err_gapped();
    int sent;
    int cycles;
    pulse_release();
    for (int i = 0; i < 10; i++) send(32'(500 + i));
    rd(8'd3, rd_d, rd_v, rd_e);
    tests++;
    if (rd_e !== 1'b1 || rd_v !== 1'b0 || rd_d !== 32'd0) begin
      fails++; $display("FAIL read_refused: err=%b valid=%b data=%0d, required 1 0 0", rd_e, rd_v, rd_d);
    end
    tick();
    tests++;
    if (bus.sink_rd_err_o !== 1'b0 || bus.sink_count_o !== 9'd10) begin
      fails++; $display("FAIL read_err_pulse: err=%b count=%0d, required 0 10", bus.sink_rd_err_o, bus.sink_count_o);
    end
    sent = 10;
    cycles = 0;
    while (sent < N && cycles < 5000) begin
      if ($urandom_range(1, 0) == 1) begin
        send(32'(500 + sent));
        sent++;
      end else begin
        tick();
      end
      cycles++;
    end
    tests++;
    if (sent != N || bus.sink_full_o !== 1'b1) begin
      fails++; $display("FAIL gapped_fill: sent=%0d full=%b, required 256 1", sent, bus.sink_full_o);
    end
    for (int a = 0; a < N; a++) begin
      rd(8'(a), rd_d, rd_v, rd_e);
      tests++;
      if (rd_v !== 1'b1 || rd_d !== 32'(500 + a)) begin
        fails++; $display("FAIL gapped_read[%0d]: valid=%b data=%0d, required 1 %0d", a, rd_v, rd_d, 500 + a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reduce();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_read_err_gapped();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
